// File: rtl/rv_wb_pkg.sv
// Shared widths and the write-request record for the writeback arbiter.
package rv_wb_pkg;
  localparam int WB_DATA_WIDTH    = 32;
  localparam int WB_ADDRESS_WIDTH = 5;

  typedef struct packed {
    logic [WB_ADDRESS_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]    data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// MDU result handshake: producer drives valid/rd/data, arbiter answers ready.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     valid;
  logic                     ready;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]    data;

  modport master (output valid, rd, data, input ready);
  modport slave  (input valid, rd, data, output ready);
endinterface

// File: rtl/wb_fifo.sv
// Small circular buffer for MDU results; head is visible combinationally.
module wb_fifo import rv_wb_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= bump(wr_q);
      if (do_pop)  rd_q <= bump(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and
// buffered MDU results, with starvation bound and a pending-write scoreboard.
module regfile_wb_arbiter import rv_wb_pkg::*; #(
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_wb_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] pipe_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    pipe_wb_data_i,
  output logic                     pipe_stall_o,
  input  logic                     mdu_issue_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] mdu_issue_rd_i,
  regfile_wb_arbiter_if.slave      mdu_res,
  input  logic [ADDRESS_WIDTH-1:0] rs1_i,
  input  logic [ADDRESS_WIDTH-1:0] rs2_i,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  output logic                     rf_we_o,
  output logic [ADDRESS_WIDTH-1:0] rf_a3_o,
  output logic [DATA_WIDTH-1:0]    rf_wd3_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int NR = 2 ** ADDRESS_WIDTH;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } req_t;

  req_t          push_req, head;
  logic          full, empty, head_win, head_wr, pipe_wr;
  logic [SW-1:0] starve_q, starve_d;
  logic [NR-1:0] busy_q, busy_d, busy_set, busy_clr;

  assign push_req.rd   = mdu_res.rd;
  assign push_req.data = mdu_res.data;
  assign mdu_res.ready = ~full;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (mdu_res.valid),
    .din_i   (push_req),
    .pop_i   (head_win),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // An rd=0 head still wins (and is dropped) but leaves the port to the pipeline.
  assign head_win = ~empty & (~pipe_wb_valid_i | (starve_q >= SW'(STARVE_LIMIT)));
  assign head_wr  = head_win & (head.rd != '0);
  assign pipe_wr  = pipe_wb_valid_i & (pipe_wb_rd_i != '0) & ~head_wr;

  assign pipe_stall_o = rst_n & pipe_wb_valid_i & (pipe_wb_rd_i != '0) & head_wr;
  assign rf_we_o      = rst_n & (head_wr | pipe_wr);
  assign rf_a3_o      = head_wr ? head.rd   : pipe_wb_rd_i;
  assign rf_wd3_o     = head_wr ? head.data : pipe_wb_data_i;

  always_comb begin
    starve_d = starve_q;
    if (head_win)                                    starve_d = '0;
    else if (!empty && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  // Set beats clear so a re-issue to the register being retired stays pending.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (mdu_issue_valid_i) busy_set[mdu_issue_rd_i] = 1'b1;
    if (head_win)          busy_clr[head.rd]        = 1'b1;
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: arbitration, starvation, scoreboard, reset.
module tb_regfile_wb_arbiter;
  logic        clk, rst_n;
  logic        pv, iv;
  logic [4:0]  prd, ird, rs1, rs2, a3;
  logic [31:0] pdata, wd3;
  logic        stall, b1, b2, we;
  int          n_chk, n_fail;

  regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) mdu_if ();

  regfile_wb_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pipe_wb_valid_i   (pv),
    .pipe_wb_rd_i      (prd),
    .pipe_wb_data_i    (pdata),
    .pipe_stall_o      (stall),
    .mdu_issue_valid_i (iv),
    .mdu_issue_rd_i    (ird),
    .mdu_res           (mdu_if),
    .rs1_i             (rs1),
    .rs2_i             (rs2),
    .rs1_busy_o        (b1),
    .rs2_busy_o        (b2),
    .rf_we_o           (we),
    .rf_a3_o           (a3),
    .rf_wd3_o          (wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pv = 0; prd = 0; pdata = 0; iv = 0; ird = 0;
    mdu_if.valid = 0; mdu_if.rd = 0; mdu_if.data = 0;
  endtask

  task automatic pipe(input logic [4:0] r, input logic [31:0] d);
    pv = 1; prd = r; pdata = d;
  endtask

  task automatic res(input logic [4:0] r, input logic [31:0] d);
    mdu_if.valid = 1; mdu_if.rd = r; mdu_if.data = d;
  endtask

  // Issuing to a register that still has a pending MDU write is illegal.
  task automatic issue(input logic [4:0] r);
    iv = 1; ird = r; rs2 = r;
    #1 chk("issue_to_busy", b2, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 0; idle(); rs1 = 5'd3; rs2 = 5'd0;
    pipe(4, 32'h44);
    @(negedge clk); #1;
    chk("rst_we", we, 0); chk("rst_stall", stall, 0);
    chk("rst_ready", mdu_if.ready, 1); chk("rst_busy", b1, 0);
    @(negedge clk); rst_n = 1; idle();

    // Single MDU result with the pipeline idle
    @(negedge clk); issue(5);
    @(negedge clk); iv = 0; rs1 = 5; res(5, 32'hDEAD); #1;
    chk("A_busy_set", b1, 1); chk("A_ready", mdu_if.ready, 1); chk("A_we_idle", we, 0);
    @(negedge clk); mdu_if.valid = 0; #1;
    chk("A_we", we, 1); chk("A_a3", a3, 5); chk("A_wd3", wd3, 32'hDEAD); chk("A_stall", stall, 0);
    @(negedge clk); #1;
    chk("A_we_after", we, 0); chk("A_busy_clr", b1, 0);

    // Starvation bound: pipeline keeps the port four cycles, then one stall
    @(negedge clk); pipe(7, 32'h77); res(9, 32'h99); issue(9);
    chk("B_a3_push", a3, 7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); iv = 0; mdu_if.valid = 0; rs2 = 9; #1;
      chk("B_pipe_a3", a3, 7); chk("B_pipe_wd3", wd3, 32'h77); chk("B_pipe_stall", stall, 0);
    end
    @(negedge clk); #1;
    chk("B_mdu_we", we, 1); chk("B_mdu_a3", a3, 9); chk("B_mdu_wd3", wd3, 32'h99);
    chk("B_mdu_stall", stall, 1); chk("B_busy9", b2, 1);
    @(negedge clk); #1;
    chk("B_after_stall", stall, 0); chk("B_after_a3", a3, 7); chk("B_busy9_clr", b2, 0);
    @(negedge clk); idle();

    // Back-to-back results fill the buffer; order preserved on drain
    @(negedge clk); issue(10);
    @(negedge clk); issue(11);
    @(negedge clk); issue(12);
    @(negedge clk); iv = 0; pipe(7, 32'h77); res(10, 32'hA0); #1;
    chk("C_ready0", mdu_if.ready, 1); chk("C_a3_0", a3, 7);
    @(negedge clk); res(11, 32'hB0); #1;
    chk("C_ready1", mdu_if.ready, 1); chk("C_a3_1", a3, 7); chk("C_stall1", stall, 0);
    @(negedge clk); res(12, 32'hC0); #1;
    chk("C_ready_full", mdu_if.ready, 0); chk("C_a3_2", a3, 7);
    @(negedge clk); pv = 0; #1;
    chk("C_ready_full2", mdu_if.ready, 0); chk("C_we_10", we, 1);
    chk("C_a3_10", a3, 10); chk("C_wd3_10", wd3, 32'hA0);
    @(negedge clk); #1;
    chk("C_ready_free", mdu_if.ready, 1); chk("C_a3_11", a3, 11); chk("C_wd3_11", wd3, 32'hB0);
    @(negedge clk); mdu_if.valid = 0; #1;
    chk("C_a3_12", a3, 12); chk("C_wd3_12", wd3, 32'hC0);
    @(negedge clk); rs1 = 12; #1;
    chk("C_drained_we", we, 0); chk("C_busy12_clr", b1, 0);

    // Re-issue on the cycle the same rd retires keeps it busy
    @(negedge clk); issue(3);
    @(negedge clk); iv = 0; res(3, 32'h33);
    @(negedge clk); mdu_if.valid = 0; iv = 1; ird = 3; rs1 = 3; #1;
    chk("D_we", we, 1); chk("D_a3", a3, 3); chk("D_busy_pre", b1, 1);
    @(negedge clk); iv = 0; #1;
    chk("D_busy_kept", b1, 1);
    @(negedge clk); res(3, 32'h34);
    @(negedge clk); mdu_if.valid = 0; #1;
    chk("D_wd3", wd3, 32'h34);
    @(negedge clk); #1;
    chk("D_busy_clr", b1, 0);

    // Head with rd=0 is dropped without stalling the pipeline write
    @(negedge clk); res(0, 32'h55); issue(13);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); iv = 0; mdu_if.valid = 0; pipe(4, 32'h44); #1;
      chk("E_pipe_a3", a3, 4);
    end
    @(negedge clk); res(13, 32'hD0); #1;
    chk("E_pop0_we", we, 1); chk("E_pop0_a3", a3, 4); chk("E_pop0_wd3", wd3, 32'h44);
    chk("E_pop0_stall", stall, 0); chk("E_pop0_ready", mdu_if.ready, 1);
    @(negedge clk); pv = 0; mdu_if.valid = 0; #1;
    chk("E_next_we", we, 1); chk("E_next_a3", a3, 13); chk("E_next_wd3", wd3, 32'hD0);
    @(negedge clk); rs1 = 13; #1;
    chk("E_busy13_clr", b1, 0); chk("E_empty_we", we, 0);

    // Asynchronous reset with two results buffered
    @(negedge clk); pipe(7, 32'h77); issue(20);
    @(negedge clk); issue(21); res(20, 32'hE0);
    @(negedge clk); iv = 0; res(21, 32'hE1);
    @(negedge clk); mdu_if.valid = 0; rs1 = 20; rs2 = 21; #1;
    chk("F_full", mdu_if.ready, 0); chk("F_busy20", b1, 1);
    #2 rst_n = 0;
    #1;
    chk("F_rst_we", we, 0); chk("F_rst_stall", stall, 0); chk("F_rst_ready", mdu_if.ready, 1);
    chk("F_rst_busy20", b1, 0); chk("F_rst_busy21", b2, 0);
    @(negedge clk); rst_n = 1; idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("F_post_we", we, 0); chk("F_post_ready", mdu_if.ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, register data width; ADDRESS_WIDTH, 5, register index width; FIFO_DEPTH, 2, MDU result buffer entries; STARVE_LIMIT, 4, maximum cycles a buffered MDU result waits behind the pipeline.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pipe_wb_valid  in  1  pipeline WB stage holds a register write.
REQ-006 pipe_wb_rd  in  ADDRESS_WIDTH  pipeline destination register.
REQ-007 pipe_wb_data  in  DATA_WIDTH  pipeline write data.
REQ-008 pipe_stall  out  1  pipeline WB must hold this cycle.
REQ-009 mdu_issue_valid / mdu_issue_rd  in  1 / ADDRESS_WIDTH  multi-cycle op issued, with its destination.
REQ-010 mdu_res_valid / mdu_res_rd / mdu_res_data  in  1 / ADDRESS_WIDTH / DATA_WIDTH  MDU result offered.
REQ-011 mdu_res_ready  out  1  result accepted when high with mdu_res_valid.
REQ-012 rs1, rs2  in  ADDRESS_WIDTH  decode-stage source indices; rs1_busy, rs2_busy  out  1  source has a pending MDU write.
REQ-013 rf_we / rf_a3 / rf_wd3  out  1 / ADDRESS_WIDTH / DATA_WIDTH  register-file write port (WE3/A3/WD3).

Function
REQ-014 MDU results SHALL enter a FIFO_DEPTH-entry FIFO; mdu_res_ready = FIFO not full, so a push can never target a full FIFO.
REQ-015 Write-port outputs SHALL be combinational from the current inputs and the FIFO head (0-cycle latency), so the register file's falling-edge write lands in the same cycle.
REQ-016 Grant: the FIFO head wins if it is non-empty AND (pipe_wb_valid=0 OR starve_cnt >= STARVE_LIMIT); otherwise the pipeline wins when pipe_wb_valid=1.
REQ-017 pipe_stall SHALL be 1 exactly when pipe_wb_valid=1, pipe_wb_rd!=0 and the FIFO head wins with a nonzero rd.
REQ-018 A winning write with rd=0 SHALL drive rf_we=0; a FIFO head with rd=0 SHALL be popped without using the port and without stalling the pipeline, and the pipeline write proceeds in the same cycle.
REQ-019 The FIFO SHALL pop on the cycle its head is granted; push and pop in the same cycle are allowed at any occupancy below full.
REQ-020 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and not popped, and SHALL clear on every pop.
REQ-021 Scoreboard: busy[r] SHALL set on mdu_issue_valid with mdu_issue_rd=r!=0 and clear when a FIFO entry with rd=r is popped; a simultaneous set and clear on the same r SHALL leave it set.
REQ-022 busy[0] SHALL always read 0; rsN_busy = busy[rsN] (combinational).
REQ-023 Pipeline writes SHALL NOT affect the scoreboard.
REQ-024 An issue to an already-busy rd is illegal; the bench SHALL assert on it.

Reset
REQ-025 While rst_n=0: FIFO empty, starve_cnt=0, busy all 0, rf_we=0, pipe_stall=0, mdu_res_ready=1.
REQ-026 Reset mid-operation SHALL discard buffered results and scoreboard bits immediately, asynchronously.

Structure
REQ-027 Package rv_wb_pkg SHALL hold DATA_WIDTH/ADDRESS_WIDTH defaults and typedef wb_req_t {rd, data}.
REQ-028 The FIFO SHALL be a sub-module wb_fifo (parameterised depth, full/empty flags).

Verification
REQ-029 MDU result rd=5, data=0xDEAD with the pipeline idle -> rf_we=1, rf_a3=5, rf_wd3=0xDEAD on the cycle after acceptance; busy[5] clears.
REQ-030 Pipeline writes every cycle (rd=7) and one MDU result is buffered (rd=9) -> pipeline wins for 4 cycles, then the MDU result is written with pipe_stall=1 for exactly one cycle.
REQ-031 Three back-to-back MDU results while the pipeline is busy -> mdu_res_ready falls after 2 are buffered; no result is lost; write order is preserved.
REQ-032 Issue rd=3 and pop rd=3 in the same cycle -> busy[3] remains 1; rs1=3 gives rs1_busy=1.
REQ-033 FIFO head rd=0 with pipeline rd=4 valid -> head is popped, rf_a3=4 is written, pipe_stall=0.
REQ-034 rst_n pulsed low with 2 entries buffered -> all outputs at reset values; no write issued after release.
